// File: rtl/player_motion_ctrl_if.sv
// Signal bundle between the keyboard/collision logic and the player motion
// controller; master drives frame/key/collision inputs, slave returns sprite state.
interface player_motion_ctrl_if;
   logic        frame_vs;
   logic [15:0] keycode;
   logic        initialize_level;
   logic        hit;
   logic [3:0]  wall_block;
   logic [9:0]  player_x;
   logic [9:0]  player_y;
   logic        player_visible;
   logic        dead_pulse;
   logic [7:0]  death_count;

   modport master (
      output frame_vs, keycode, initialize_level, hit, wall_block,
      input  player_x, player_y, player_visible, dead_pulse, death_count
   );

   modport slave (
      input  frame_vs, keycode, initialize_level, hit, wall_block,
      output player_x, player_y, player_visible, dead_pulse, death_count
   );
endinterface

// File: rtl/player_motion_ctrl.sv
// Per-frame player sprite controller: moves the player square from WASD keys once per
// vsync, handles death/blink/respawn and keeps a saturating death counter.
module player_motion_ctrl #(
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 639,
   parameter int Y_MIN        = 0,
   parameter int Y_MAX        = 479,
   parameter int SIZE         = 12,
   parameter int STEP         = 1,
   parameter int SPAWN_X      = 100,
   parameter int SPAWN_Y      = 240,
   parameter int DEATH_FRAMES = 30
) (
   input  logic                 Clk,
   input  logic                 Reset,
   player_motion_ctrl_if.slave  bus
);

   localparam int CW = $clog2(DEATH_FRAMES + 1);

   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] X_LO   = 11'(X_MIN);
   localparam logic signed [10:0] X_HI   = 11'(X_MAX - SIZE + 1);
   localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
   localparam logic signed [10:0] Y_HI   = 11'(Y_MAX - SIZE + 1);

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;

   typedef enum logic [0:0] {
      ALIVE = 1'b0,
      DYING = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          vis_q, vis_d;
   logic          pulse_q, pulse_d;
   logic [7:0]    deaths_q, deaths_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          vs_r1_q, vs_r1_d;
   logic          vs_r2_q, vs_r2_d;

   logic          tick;
   logic          key_w, key_a, key_s, key_d;
   logic signed [10:0] dx, dy, nx, ny;
   logic [9:0]    x_mov, y_mov;
   logic [CW-1:0] cnt_dec;

   // Rising edge of the active-low vsync marks the end of the sync pulse.
   assign vs_r1_d = bus.frame_vs;
   assign vs_r2_d = vs_r1_q;
   assign tick    = vs_r1_q & ~vs_r2_q;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= ALIVE;
         x_q      <= 10'(SPAWN_X);
         y_q      <= 10'(SPAWN_Y);
         vis_q    <= 1'b1;
         pulse_q  <= 1'b0;
         deaths_q <= 8'd0;
         cnt_q    <= '0;
         vs_r1_q  <= 1'b1;
         vs_r2_q  <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vis_q    <= vis_d;
         pulse_q  <= pulse_d;
         deaths_q <= deaths_d;
         cnt_q    <= cnt_d;
         vs_r1_q  <= vs_r1_d;
         vs_r2_q  <= vs_r2_d;
      end
   end

   // Key decode, wall blocking and edge clamping of the candidate position.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      key_w = (bus.keycode[7:0] == KEY_W) || (bus.keycode[15:8] == KEY_W);
      key_a = (bus.keycode[7:0] == KEY_A) || (bus.keycode[15:8] == KEY_A);
      key_s = (bus.keycode[7:0] == KEY_S) || (bus.keycode[15:8] == KEY_S);
      key_d = (bus.keycode[7:0] == KEY_D) || (bus.keycode[15:8] == KEY_D);

      dx = '0;
      dy = '0;
      if (key_d) dx = dx + STEP_S;
      if (key_a) dx = dx - STEP_S;
      if (key_s) dy = dy + STEP_S;
      if (key_w) dy = dy - STEP_S;

      if (dx > 11'sd0 && bus.wall_block[0]) dx = '0;
      if (dx < 11'sd0 && bus.wall_block[2]) dx = '0;
      if (dy > 11'sd0 && bus.wall_block[1]) dy = '0;
      if (dy < 11'sd0 && bus.wall_block[3]) dy = '0;

      nx = $signed({1'b0, x_q}) + dx;
      ny = $signed({1'b0, y_q}) + dy;

      if (nx < X_LO)      x_mov = X_LO[9:0];
      else if (nx > X_HI) x_mov = X_HI[9:0];
      else                x_mov = nx[9:0];

      if (ny < Y_LO)      y_mov = Y_LO[9:0];
      else if (ny > Y_HI) y_mov = Y_HI[9:0];
      else                y_mov = ny[9:0];
   end

   // Next-state logic; initialize_level overrides everything, every cycle.
   always_comb begin
      state_d = state_q;
      if (bus.initialize_level) begin
         state_d = ALIVE;
      end else if (tick) begin
         case (state_q)
            ALIVE:   if (bus.hit) state_d = DYING;
            DYING:   if (cnt_q == CW'(1)) state_d = ALIVE;
            default: state_d = ALIVE;
         endcase
      end
   end

   // Output / datapath next values.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      vis_d    = vis_q;
      pulse_d  = 1'b0;
      deaths_d = deaths_q;
      cnt_d    = cnt_q;
      cnt_dec  = cnt_q - CW'(1);

      if (bus.initialize_level) begin
         x_d   = 10'(SPAWN_X);
         y_d   = 10'(SPAWN_Y);
         vis_d = 1'b1;
         cnt_d = '0;
      end else if (tick) begin
         case (state_q)
            ALIVE: begin
               if (bus.hit) begin
                  cnt_d   = CW'(DEATH_FRAMES);
                  pulse_d = 1'b1;
                  if (deaths_q != 8'hFF) deaths_d = deaths_q + 8'd1;
               end else begin
                  x_d = x_mov;
                  y_d = y_mov;
               end
            end
            DYING: begin
               if (cnt_q == CW'(1)) begin
                  x_d   = 10'(SPAWN_X);
                  y_d   = 10'(SPAWN_Y);
                  vis_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  // Blink follows bit 2 of the freshly decremented counter.
                  cnt_d = cnt_dec;
                  vis_d = ~cnt_dec[2];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.player_x       = x_q;
   assign bus.player_y       = y_q;
   assign bus.player_visible = vis_q;
   assign bus.dead_pulse     = pulse_q;
   assign bus.death_count    = deaths_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: a behavioural model pushes the expected
// sprite state at each vsync tick, the checks pop it after the DUT updates.
module tb_player_motion_ctrl;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vis;
      logic [7:0] deaths;
   } snap_t;

   logic Clk = 1'b0;
   logic Reset;
   always #10 Clk = ~Clk;

   player_motion_ctrl_if bus ();

   player_motion_ctrl dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   snap_t sb[$];
   int total = 0;
   int bad   = 0;

   int m_x, m_y, m_cnt, m_deaths, m_pulses;
   bit m_vis, m_dying;
   int pulse_seen;

   always @(posedge Clk or posedge Reset) begin
      if (Reset)               pulse_seen <= 0;
      else if (bus.dead_pulse) pulse_seen <= pulse_seen + 1;
   end

   function automatic snap_t observe();
      snap_t s;
      s.x = bus.player_x; s.y = bus.player_y;
      s.vis = bus.player_visible; s.deaths = bus.death_count;
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.x = 10'(m_x); s.y = 10'(m_y); s.vis = m_vis; s.deaths = 8'(m_deaths);
      return s;
   endfunction

   function automatic string fmt(input snap_t s);
      return $sformatf("x=%0d y=%0d vis=%0b deaths=%0d", s.x, s.y, s.vis, s.deaths);
   endfunction

   function automatic bit pressed(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_reset();
      m_x = 100; m_y = 240; m_vis = 1; m_dying = 0; m_cnt = 0; m_deaths = 0; m_pulses = 0;
      sb.delete();
   endtask

   task automatic model_init();
      m_x = 100; m_y = 240; m_vis = 1; m_dying = 0; m_cnt = 0;
   endtask

   task automatic model_tick(input logic [15:0] kc, input logic h, input logic [3:0] wb);
      int dx, dy;
      if (m_dying) begin
         if (m_cnt == 1) begin
            m_dying = 0; m_x = 100; m_y = 240; m_vis = 1; m_cnt = 0;
         end else begin
            m_cnt = m_cnt - 1;
            m_vis = ((m_cnt / 4) % 2) == 0;
         end
      end else if (h) begin
         m_dying = 1; m_cnt = 30; m_pulses++;
         if (m_deaths < 255) m_deaths++;
      end else begin
         dx = (pressed(kc, 8'h07) ? 1 : 0) - (pressed(kc, 8'h04) ? 1 : 0);
         dy = (pressed(kc, 8'h16) ? 1 : 0) - (pressed(kc, 8'h1A) ? 1 : 0);
         if (dx > 0 && wb[0]) dx = 0;
         if (dx < 0 && wb[2]) dx = 0;
         if (dy > 0 && wb[1]) dy = 0;
         if (dy < 0 && wb[3]) dy = 0;
         m_x = clamp(m_x + dx, 0, 628);
         m_y = clamp(m_y + dy, 0, 468);
      end
   endtask

   // One vsync frame: low two cycles, rise, then return after the update edge.
   task automatic step_frame(input logic [15:0] kc, input logic h, input logic [3:0] wb);
      @(negedge Clk);
      bus.frame_vs = 1'b0; bus.keycode = kc; bus.hit = h; bus.wall_block = wb;
      repeat (2) @(negedge Clk);
      if (bus.initialize_level) model_init();
      else                      model_tick(kc, h, wb);
      sb.push_back(model_snap());
      bus.frame_vs = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic pulse_init();
      @(negedge Clk);
      bus.initialize_level = 1'b1;
      @(negedge Clk);
      bus.initialize_level = 1'b0;
      model_init();
   endtask

   task automatic test_reset();
      snap_t exp_s, obs_s, prev_s;
      Reset = 1'b1;
      bus.frame_vs = 1'b1; bus.keycode = 16'h001A; bus.initialize_level = 1'b0;
      bus.hit = 1'b0; bus.wall_block = 4'b0000;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      obs_s = observe(); total++;
      if (obs_s !== model_snap() || bus.dead_pulse !== 1'b0) begin
         bad++; $display("FAIL reset_state: got %s pulse=%0b, want %s pulse=0", fmt(obs_s), bus.dead_pulse, fmt(model_snap()));
      end
      repeat (4) @(negedge Clk);
      total++;
      if (bus.player_x !== 10'd100 || bus.player_y !== 10'd240) begin
         bad++; $display("FAIL no_false_tick: got x=%0d y=%0d, want x=100 y=240", bus.player_x, bus.player_y);
      end
      for (int f = 0; f < 3; f++) begin
         @(negedge Clk); bus.frame_vs = 1'b0;
         repeat (2) @(negedge Clk);
         prev_s = model_snap();
         model_tick(16'h001A, 1'b0, 4'b0000);
         sb.push_back(model_snap());
         bus.frame_vs = 1'b1;
         @(negedge Clk);
         obs_s = observe(); total++;
         if (obs_s !== prev_s) begin
            bad++; $display("FAIL latency_one_edge f%0d: got %s, want %s", f, fmt(obs_s), fmt(prev_s));
         end
         @(negedge Clk);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; $display("FAIL move_up f%0d: got %s, want %s", f, fmt(obs_s), fmt(exp_s));
         end
      end
      total++;
      if (bus.player_x !== 10'd100 || bus.player_y !== 10'd237) begin
         bad++; $display("FAIL move_up_final: got x=%0d y=%0d, want x=100 y=237", bus.player_x, bus.player_y);
      end
   endtask

   task automatic test_move_block();
      logic [15:0] kc_t [6] = '{16'h0704, 16'h0704, 16'h0007, 16'h0007, 16'h0016, 16'h001A};
      logic [3:0]  wb_t [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1000};
      snap_t exp_s, obs_s;
      for (int i = 0; i < 6; i++) begin
         step_frame(kc_t[i], 1'b0, wb_t[i]);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; $display("FAIL move_block step%0d: got %s, want %s", i, fmt(obs_s), fmt(exp_s));
         end
      end
      total++;
      if (bus.player_x !== 10'd101 || bus.player_y !== 10'd237) begin
         bad++; $display("FAIL move_block_final: got x=%0d y=%0d, want x=101 y=237", bus.player_x, bus.player_y);
      end
      // Key change between ticks must not move the sprite.
      bus.keycode = 16'h0016;
      repeat (5) @(negedge Clk);
      obs_s = observe(); total++;
      if (obs_s !== model_snap()) begin
         bad++; $display("FAIL midframe_key: got %s, want %s", fmt(obs_s), fmt(model_snap()));
      end
   endtask

   task automatic test_clamp();
      snap_t exp_s, obs_s;
      int nerr = 0;
      pulse_init();
      for (int i = 0; i < 1300; i++) begin
         step_frame((i < 600) ? 16'h0007 : 16'h1A04, 1'b0, 4'b0000);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; nerr++;
            if (nerr < 5) $display("FAIL clamp frame%0d: got %s, want %s", i, fmt(obs_s), fmt(exp_s));
         end
         if (i == 599) begin
            total++;
            if (bus.player_x !== 10'd628) begin
               bad++; $display("FAIL clamp_right: got x=%0d, want x=628", bus.player_x);
            end
         end
         if (i == 799) begin
            total++;
            if (bus.player_x !== 10'd428 || bus.player_y !== 10'd40) begin
               bad++; $display("FAIL diag_wa: got x=%0d y=%0d, want x=428 y=40", bus.player_x, bus.player_y);
            end
         end
      end
      total++;
      if (bus.player_x !== 10'd0 || bus.player_y !== 10'd0) begin
         bad++; $display("FAIL clamp_topleft: got x=%0d y=%0d, want x=0 y=0", bus.player_x, bus.player_y);
      end
   endtask

   task automatic test_death();
      snap_t exp_s, obs_s;
      pulse_init();
      step_frame(16'h0007, 1'b1, 4'b0000);
      exp_s = sb.pop_front(); obs_s = observe(); total++;
      if (obs_s !== exp_s) begin
         bad++; $display("FAIL death_enter: got %s, want %s", fmt(obs_s), fmt(exp_s));
      end
      total++;
      if (bus.dead_pulse !== 1'b1) begin
         bad++; $display("FAIL dead_pulse_high: got %0b, want 1", bus.dead_pulse);
      end
      @(negedge Clk);
      total++;
      if (bus.dead_pulse !== 1'b0) begin
         bad++; $display("FAIL dead_pulse_one_cycle: got %0b, want 0", bus.dead_pulse);
      end
      for (int i = 0; i < 30; i++) begin
         step_frame(16'h0007, 1'b0, 4'b0000);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; $display("FAIL dying tick%0d: got %s, want %s", i, fmt(obs_s), fmt(exp_s));
         end
      end
      total++;
      if (bus.player_x !== 10'd100 || bus.player_y !== 10'd240 || bus.player_visible !== 1'b1 || bus.death_count !== 8'd1) begin
         bad++; $display("FAIL respawn: got %s, want x=100 y=240 vis=1 deaths=1", fmt(observe()));
      end
      step_frame(16'h0007, 1'b0, 4'b0000);
      exp_s = sb.pop_front(); obs_s = observe(); total++;
      if (obs_s !== exp_s) begin
         bad++; $display("FAIL alive_after_respawn: got %s, want %s", fmt(obs_s), fmt(exp_s));
      end
      @(negedge Clk);
      total++;
      if (pulse_seen !== m_pulses) begin
         bad++; $display("FAIL pulse_count_death: got %0d, want %0d", pulse_seen, m_pulses);
      end
   endtask

   task automatic test_init();
      snap_t exp_s, obs_s;
      step_frame(16'h0000, 1'b1, 4'b0000);
      void'(sb.pop_front());
      for (int i = 0; i < 5; i++) begin
         step_frame(16'h0007, 1'b0, 4'b0000);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; $display("FAIL init_pre tick%0d: got %s, want %s", i, fmt(obs_s), fmt(exp_s));
         end
      end
      pulse_init();
      obs_s = observe(); total++;
      if (obs_s !== model_snap()) begin
         bad++; $display("FAIL init_mid_dying: got %s, want %s", fmt(obs_s), fmt(model_snap()));
      end
      step_frame(16'h0007, 1'b0, 4'b0000);
      exp_s = sb.pop_front(); obs_s = observe(); total++;
      if (obs_s !== exp_s) begin
         bad++; $display("FAIL init_then_move: got %s, want %s", fmt(obs_s), fmt(exp_s));
      end
      bus.initialize_level = 1'b1;
      step_frame(16'h0007, 1'b1, 4'b0000);
      bus.initialize_level = 1'b0;
      exp_s = sb.pop_front(); obs_s = observe(); total++;
      if (obs_s !== exp_s || bus.dead_pulse !== 1'b0) begin
         bad++; $display("FAIL init_beats_hit: got %s pulse=%0b, want %s pulse=0", fmt(obs_s), bus.dead_pulse, fmt(exp_s));
      end
      @(negedge Clk);
      total++;
      if (pulse_seen !== m_pulses) begin
         bad++; $display("FAIL pulse_count_init: got %0d, want %0d", pulse_seen, m_pulses);
      end
   endtask

   task automatic test_saturate();
      snap_t exp_s, obs_s;
      int nerr = 0;
      for (int i = 0; i < 260 * 31; i++) begin
         step_frame(16'h0007, 1'b1, 4'b0000);
         exp_s = sb.pop_front(); obs_s = observe(); total++;
         if (obs_s !== exp_s) begin
            bad++; nerr++;
            if (nerr < 5) $display("FAIL saturate frame%0d: got %s, want %s", i, fmt(obs_s), fmt(exp_s));
         end
      end
      @(negedge Clk);
      total++;
      if (bus.death_count !== 8'd255) begin
         bad++; $display("FAIL death_saturate: got %0d, want 255", bus.death_count);
      end
      total++;
      if (pulse_seen !== m_pulses) begin
         bad++; $display("FAIL pulse_count_sat: got %0d, want %0d", pulse_seen, m_pulses);
      end
   endtask

   task automatic test_reset_mid_move();
      snap_t exp_s, obs_s;
      @(negedge Clk);
      bus.frame_vs = 1'b0; bus.keycode = 16'h0016; bus.hit = 1'b0;
      repeat (2) @(negedge Clk);
      bus.frame_vs = 1'b1;
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1;
      total++;
      if (bus.player_x !== 10'd100 || bus.player_y !== 10'd240 || bus.player_visible !== 1'b1 ||
          bus.dead_pulse !== 1'b0 || bus.death_count !== 8'd0) begin
         bad++; $display("FAIL async_reset: got %s pulse=%0b, want x=100 y=240 vis=1 deaths=0 pulse=0", fmt(observe()), bus.dead_pulse);
      end
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      step_frame(16'h0016, 1'b0, 4'b0000);
      exp_s = sb.pop_front(); obs_s = observe(); total++;
      if (obs_s !== exp_s) begin
         bad++; $display("FAIL after_reset_move: got %s, want %s", fmt(obs_s), fmt(exp_s));
      end
   endtask

   initial begin
      test_reset();
      test_move_block();
      test_clamp();
      test_death();
      test_init();
      test_saturate();
      test_reset_mid_move();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Per-frame player sprite controller for the World's Hardest Game SoC.
- Sits directly upstream of the VGA colour/sprite stage. Consumes the USB keyboard keycode word (the same 16-bit value driven onto the SoC wasd input) plus collision flags.
- Produces the player's top-left pixel position, visibility, and death bookkeeping.
- Updates once per video frame on the end of vertical sync.

Parameters:
- X_MIN, 0, leftmost legal pixel column
- X_MAX, 639, rightmost legal pixel column
- Y_MIN, 0, top legal pixel row
- Y_MAX, 479, bottom legal pixel row
- SIZE, 12, player square side in pixels
- STEP, 1, pixels moved per frame per axis
- SPAWN_X, 100, respawn column
- SPAWN_Y, 240, respawn row
- DEATH_FRAMES, 30, frames spent in DYING before respawn

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high
- frame_vs  in  1  VGA vsync, active low, synchronous to Clk
- keycode  in  16  two HID usage codes, [7:0] and [15:8]; 0x00 = none
- initialize_level  in  1  level-sensitive; forces respawn while high
- hit  in  1  enemy collision flag; sampled only on frame tick
- wall_block  in  4  {up,left,down,right}; 1 = motion in that direction blocked this frame
- player_x  out  10  sprite left column
- player_y  out  10  sprite top row
- player_visible  out  1  sprite draw enable
- dead_pulse  out  1  one-cycle strobe on each death
- death_count  out  8  saturating death counter

Behaviour:
- Reset values (asynchronous): player_x=SPAWN_X, player_y=SPAWN_Y, player_visible=1, dead_pulse=0, death_count=0, state=ALIVE, frame counter=0.
- Reset values, continued: both vsync sample registers =1, so the first cycles after Reset never produce a false tick.

Frame tick:
- frame_vs is registered into vs_r1, then vs_r2.
- tick=vs_r1 & ~vs_r2, which is the rising (sync-end) edge.
- All state and position updates occur on the clock edge that ends the tick cycle. Outputs therefore change 2 Clk edges after frame_vs rises.
- No updates happen outside tick cycles, except initialize_level and Reset.

Key decode:
- W=0x1A, A=0x04, S=0x16, D=0x07.
- A key is pressed if either byte equals its code.
- dx=(D?+STEP:0)-(A?STEP:0); dy=(S?+STEP:0)-(W?STEP:0). Opposite keys cancel; diagonal moves are allowed.
- Blocking: a positive dx is zeroed if wall_block[0]; negative dx if [2]; positive dy if [1]; negative dy if [3].
- Arithmetic is 11-bit signed.
- New x is clamped to [X_MIN, X_MAX-SIZE+1] (default 0..628). New y is clamped to [Y_MIN, Y_MAX-SIZE+1] (default 0..468).

State machine:
- ALIVE, on tick:
  - hit=1: go to DYING, position frozen, frame counter=DEATH_FRAMES, dead_pulse=1 for exactly one cycle, death_count+=1 saturating at 255.
  - hit=0: apply movement.
- DYING, on tick:
  - Counter decrements.
  - player_visible = ~counter[2] (blinks every 4 frames).
  - keycode and hit are ignored.
  - When the counter is 1 at tick: position=spawn, player_visible=1, go to ALIVE. DYING therefore lasts exactly DEATH_FRAMES ticks.

initialize_level:
- Highest synchronous priority, evaluated every cycle, not only on tick.
- While high: state=ALIVE, position=spawn, player_visible=1, counter=0, dead_pulse=0.
- death_count is retained across levels; only Reset clears it.
- initialize_level and hit in the same tick: initialize wins, no death is counted.

Other boundaries:
- A tick while already at a clamp edge leaves position unchanged.
- Keycode change mid-frame has no effect until the next tick.

Test Plan:
1. Reset, keycode=0x001A, 3 vsync pulses -> player_y 240→237, player_x=100. Each change lands 2 Clk after frame_vs rise. No change on the first frame_vs high after Reset.
2. keycode=0x0704 (D+A) for 2 frames -> x stays 100. keycode=0x0007 with wall_block=4'b0001 -> x stays 100. wall_block=0 -> x 101.
3. keycode=0x0007 held for 600 frames -> x saturates at 628 and holds. keycode=0x1A04 for 200 frames from y=240 -> x=428 (from 628), y=40.
4. hit=1 at a tick -> dead_pulse high exactly 1 cycle, death_count=1, position frozen. player_visible blinks with the counter[2] pattern. Keys are ignored. After 30 ticks -> x=100, y=240, visible=1, ALIVE.
5. Force 260 deaths -> death_count stops at 255. hit held high during DYING -> no extra increments.
6. initialize_level pulsed for 1 cycle mid-DYING (non-tick cycle) -> next edge: ALIVE, spawn, visible=1, death_count unchanged. Reset asserted mid-move -> all outputs immediately at reset values.
